// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-16-bit-memory bridge: widths, FSM
// state encoding and the byte-enable helper.
package mem_bridge_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TAG_W  = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    WDONE = 2'd3
  } state_t;

  // Byte enable for a single-byte access; bit0 is the even (low) byte.
  function automatic logic [1:0] byte_be(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bridge_buf.sv
// One-word read buffer with tag/valid and a byte write port.
//   clock, reset_n : clock and asynchronous active-low reset
//   lookup_tag     : word address of the current CPU access
//   load/load_data : fill the buffer with a whole word, tagged lookup_tag
//   wr_en/wr_hi/wr_byte : byte update, applied only when lookup_tag hits
//   hit            : buffer valid and tag matches lookup_tag
//   data           : buffered word
module mem_bridge_buf
  import mem_bridge_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              wr_en,
  input  logic              wr_hi,
  input  logic [BYTE_W-1:0] wr_byte,
  output logic              hit,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] buf_data;
  logic [TAG_W-1:0]  buf_tag;
  logic              buf_vld;

  assign hit  = buf_vld && (buf_tag == lookup_tag);
  assign data = buf_data;

  // Fill on read completion; write-through keeps a hitting word coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_data <= '0;
      buf_tag  <= '0;
      buf_vld  <= 1'b0;
    end else if (load) begin
      buf_data <= load_data;
      buf_tag  <= lookup_tag;
      buf_vld  <= 1'b1;
    end else if (wr_en && hit) begin
      if (wr_hi) buf_data[WORD_W-1:BYTE_W] <= wr_byte;
      else       buf_data[BYTE_W-1:0]      <= wr_byte;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridges an 8-bit CPU bus (clock-enable handshake) to a 16-bit
// request/acknowledge memory, with a one-word read buffer giving
// zero-wait-state reads on a hit.
//   clock, reset_n        : clock, asynchronous active-low reset
//   cpu_a/cpu_o/cpu_w     : CPU byte address, write data, write strobe
//   cpu_i, cpu_ce         : read data to CPU, access-complete enable
//   mem_a/mem_d/mem_be    : word address, replicated write data, byte enables
//   mem_we, mem_req       : write qualifier, request held until mem_ack
//   mem_ack, mem_q        : completion pulse and read data from memory
module mem_bridge
  import mem_bridge_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [BYTE_W-1:0] cpu_o,
  input  logic              cpu_w,
  output logic [BYTE_W-1:0] cpu_i,
  output logic              cpu_ce,
  output logic [TAG_W-1:0]  mem_a,
  output logic [WORD_W-1:0] mem_d,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_q
);

  state_t            state, state_nxt;
  logic              hit;
  logic              buf_load;
  logic              buf_wr;
  logic [WORD_W-1:0] buf_q;

  // CPU inputs are held stable until cpu_ce, so they feed the memory directly.
  assign mem_a = cpu_a[ADDR_W-1:1];
  assign mem_d = {cpu_o, cpu_o};
  assign cpu_i = cpu_a[0] ? buf_q[WORD_W-1:BYTE_W] : buf_q[BYTE_W-1:0];

  mem_bridge_buf u_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .lookup_tag (cpu_a[ADDR_W-1:1]),
    .load       (buf_load),
    .load_data  (mem_q),
    .wr_en      (buf_wr),
    .wr_hi      (cpu_a[0]),
    .wr_byte    (cpu_o),
    .hit        (hit),
    .data       (buf_q)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and outputs; mem_req/mem_we decode from state so reset drops them at once.
  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_w)    state_nxt = WR;
        else if (hit) cpu_ce    = 1'b1;
        else          state_nxt = RD;
      end
      RD: begin
        mem_req = 1'b1;
        mem_be  = 2'b11;
        if (mem_ack) begin
          buf_load  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_be  = byte_be(cpu_a[0]);
        if (mem_ack) begin
          buf_wr    = 1'b1;
          state_nxt = WDONE;
        end
      end
      WDONE: begin
        cpu_ce    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: the bench plays CPU and memory,
// predicts every cycle from a transaction-level model (memory array plus
// one-word buffer image) and pins the model with literal scenario values.
module tb_mem_bridge;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic [18:0] mem_a;
  logic [15:0] mem_d;
  logic [1:0]  mem_be;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_q;

  always #5 clock = ~clock;

  mem_bridge dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cpu_a   (cpu_a),
    .cpu_o   (cpu_o),
    .cpu_w   (cpu_w),
    .cpu_i   (cpu_i),
    .cpu_ce  (cpu_ce),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_be  (mem_be),
    .mem_we  (mem_we),
    .mem_req (mem_req),
    .mem_ack (mem_ack),
    .mem_q   (mem_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle outputs and model state.
  logic        chk_en = 1'b0;
  logic        e_ce, e_req, e_we;
  logic [1:0]  e_be;
  logic        m_vld;
  logic [18:0] m_tag;
  logic [15:0] m_data;
  logic [15:0] mem_mod [logic [18:0]];

  // Observations accumulated by the compare process.
  int          cyc_total = 0;
  int          req_total = 0;
  int          ce_cyc    = 0;
  logic [7:0]  ce_ci     = 8'h00;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic hi);
    return hi ? m_data[15:8] : m_data[7:0];
  endfunction

  // Compare process: checks every output on every enabled cycle.
  always begin
    @(negedge clock);
    if (chk_en) begin
      cyc_total++;
      if (mem_req === 1'b1) req_total++;
      if (cpu_ce === 1'b1) begin
        ce_cyc = cyc_total;
        ce_ci  = cpu_i;
      end
      check("cpu_ce", 32'(cpu_ce), 32'(e_ce));
      check("mem_req", 32'(mem_req), 32'(e_req));
      if (e_req) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_be", 32'(mem_be), 32'(e_be));
      end
      check("mem_a", 32'(mem_a), 32'(cpu_a[19:1]));
      check("mem_d", 32'(mem_d), 32'({cpu_o, cpu_o}));
      check("cpu_i", 32'(cpu_i), 32'(exp_byte(cpu_a[0])));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One CPU access from first presentation to cpu_ce; the memory acks after dly wait cycles.
  // spur drives a stray mem_ack in the cycles where no request is outstanding.
  task automatic do_access(input logic w, input logic [19:0] a, input logic [7:0] d,
                           input int dly, input bit spur, output int lat, output int nreq);
    logic [18:0] t;
    bit          hit;
    logic [15:0] wd;
    int          b_cyc, b_req;
    t     = a[19:1];
    b_cyc = cyc_total;
    b_req = req_total;
    if (!mem_mod.exists(t)) mem_mod[t] = 16'($urandom);
    hit   = m_vld && (m_tag == t);
    cpu_a = a; cpu_w = w; cpu_o = d;
    mem_ack = spur; mem_q = 16'($urandom);
    e_we  = w;
    e_be  = w ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    if (!w && hit) begin
      e_ce = 1'b1; e_req = 1'b0;
      cyc();
    end else begin
      e_ce = 1'b0; e_req = 1'b0;
      cyc();
      mem_ack = 1'b0; e_req = 1'b1;
      repeat (dly) cyc();
      mem_ack = 1'b1; mem_q = mem_mod[t];
      cyc();
      mem_ack = spur; mem_q = 16'($urandom);
      e_req = 1'b0; e_ce = 1'b1;
      if (w) begin
        wd = mem_mod[t];
        if (a[0]) wd[15:8] = d; else wd[7:0] = d;
        mem_mod[t] = wd;
        if (hit) begin
          if (a[0]) m_data[15:8] = d; else m_data[7:0] = d;
        end
      end else begin
        m_vld = 1'b1; m_tag = t; m_data = mem_mod[t];
      end
      cyc();
    end
    mem_ack = 1'b0;
    lat  = ce_cyc - b_cyc;
    nreq = req_total - b_req;
  endtask

  logic [18:0] tags [4];

  initial begin
    int lat, nreq;
    logic [19:0] a;
    logic        w;
    logic [15:0] word;
    cpu_a = '0; cpu_w = 1'b0; cpu_o = '0; mem_ack = 1'b0; mem_q = '0;
    e_ce = 1'b0; e_req = 1'b0; e_we = 1'b0; e_be = 2'b00;
    m_vld = 1'b0; m_tag = '0; m_data = '0;
    tags[0] = 19'h7F800; tags[1] = 19'h00008; tags[2] = 19'h7FFFF; tags[3] = 19'h12345;

    // Reset held: no request, no completion, buffer reads zero.
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;

    // Cold read miss, ack after 2 wait cycles.
    mem_mod[19'h7F800] = 16'hBEEA;
    do_access(1'b0, 20'hFF000, 8'h00, 2, 1'b0, lat, nreq);
    check("miss_ce_cycle", 32'(lat), 32'd5);
    check("miss_req_cycles", 32'(nreq), 32'd3);
    check("miss_cpu_i", 32'(ce_ci), 32'h0EA);

    // Other byte of the same word hits with zero wait states.
    do_access(1'b0, 20'hFF001, 8'h00, 0, 1'b0, lat, nreq);
    check("hit_ce_cycle", 32'(lat), 32'd1);
    check("hit_req_cycles", 32'(nreq), 32'd0);
    check("hit_cpu_i", 32'(ce_ci), 32'h0BE);

    // Write hit on the high byte, then read back from the buffer.
    do_access(1'b1, 20'hFF001, 8'h55, 1, 1'b0, lat, nreq);
    check("wr_ce_cycle", 32'(lat), 32'd4);
    check("wr_req_cycles", 32'(nreq), 32'd2);
    do_access(1'b0, 20'hFF001, 8'h00, 0, 1'b0, lat, nreq);
    check("wr_rb_ce_cycle", 32'(lat), 32'd1);
    check("wr_rb_req", 32'(nreq), 32'd0);
    check("wr_rb_cpu_i", 32'(ce_ci), 32'h055);

    // Write miss leaves the buffer alone; stray acks in IDLE/WDONE are ignored.
    do_access(1'b1, 20'h00010, 8'hAA, 0, 1'b1, lat, nreq);
    do_access(1'b0, 20'hFF000, 8'h00, 0, 1'b0, lat, nreq);
    check("wmiss_keep_ce", 32'(lat), 32'd1);
    check("wmiss_keep_ci", 32'(ce_ci), 32'h0EA);

    // Reset in the middle of a read with the ack still pending.
    cpu_a = 20'h12344; cpu_w = 1'b0; mem_ack = 1'b0;
    e_ce = 1'b0; e_req = 1'b0;
    cyc();
    e_req = 1'b1; e_we = 1'b0; e_be = 2'b11;
    cyc();
    #2;
    chk_en = 1'b0;
    check("rst_req_before", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_req_async", 32'(mem_req), 32'd0);
    check("rst_ce_async", 32'(cpu_ce), 32'd0);
    check("rst_we_async", 32'(mem_we), 32'd0);
    m_vld = 1'b0; m_tag = '0; m_data = '0;
    e_req = 1'b0; e_ce = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    reset_n = 1'b1;
    // Late ack in the first cycle after release, then FF000 must miss.
    do_access(1'b0, 20'hFF000, 8'h00, 1, 1'b1, lat, nreq);
    check("post_rst_miss_req", 32'(nreq), 32'd2);
    check("post_rst_ce_cycle", 32'(lat), 32'd4);
    check("post_rst_ci", 32'(ce_ci), 32'h0EA);

    // Top of the address space.
    mem_mod[19'h7FFFF] = 16'h3C96;
    do_access(1'b0, 20'hFFFFF, 8'h00, 0, 1'b0, lat, nreq);
    check("wrap_cpu_i", 32'(ce_ci), 32'h03C);
    do_access(1'b1, 20'hFFFFF, 8'h71, 2, 1'b1, lat, nreq);
    do_access(1'b0, 20'hFFFFF, 8'h00, 0, 1'b0, lat, nreq);
    check("wrap_wr_rb", 32'(ce_ci), 32'h071);

    // Random mix over a few words to exercise hits, misses and write-through.
    for (int i = 0; i < 250; i++) begin
      a = {tags[$urandom % 4], 1'($urandom)};
      w = (($urandom % 3) == 0);
      do_access(w, a, 8'($urandom), int'($urandom % 4), 1'($urandom), lat, nreq);
      if (!w) begin
        word = mem_mod[a[19:1]];
        check("rnd_rd_data", 32'(ce_ci), 32'(a[0] ? word[15:8] : word[7:0]));
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
